// File: rtl/axis_hdr_pkg.sv
// Shared types and keep-mask helpers for the AXI-Stream header extractor.
package axis_hdr_pkg;
  localparam int MAX_BYTES = 128;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {FIRST, STREAM, FLUSH} state_t;

  // Mask of cnt ones, either right-aligned or left-aligned within nbytes lanes.
  function automatic logic [MAX_BYTES-1:0] keep_from_cnt(input logic [CNT_W-1:0] cnt,
                                                         input logic [CNT_W-1:0] nbytes,
                                                         input logic left);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (i < int'(cnt)) m[i] = 1'b1;
    if (left) m = m << (nbytes - cnt);
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] keep_popcount(input logic [MAX_BYTES-1:0] k);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_BYTES; i++) c = c + CNT_W'(k[i]);
    return c;
  endfunction
endpackage

// File: rtl/axis_reg_slice.sv
// One-entry valid/ready output register; free means it can take a new entry this cycle.
module axis_reg_slice #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] d,
  output logic          free,
  output logic          valid,
  output logic [PW-1:0] q,
  input  logic          ready
);
  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips the first N bytes of each packet onto a header channel and re-packs
// the remaining payload MSB-aligned into full beats.
module axi_stream_extract_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);
  localparam int W = DATA_BYTE_WD;
  localparam logic [CNT_W-1:0] W_B = CNT_W'(W);

  state_t              state, state_nx;
  logic [DATA_WD-1:0]  res, res_nx;
  logic [CNT_W-1:0]    res_cnt, res_cnt_nx;
  logic [DATA_WD-1:0]  din_m;
  logic [CNT_W-1:0]    n, k, tot;
  logic [CNT_W+2:0]    sh_hdr, sh_pay, sh_res;
  logic [2*DATA_WD-1:0] wide;
  logic                acc, hdr_free, pay_free, hdr_load, pay_load;
  logic [DATA_WD-1:0]  hdr_d, pay_d;
  logic [W-1:0]        hdr_k, pay_k;
  logic                pay_l;

  // Bytes outside keep are zeroed so every output lane beyond keep reads zero.
  for (genvar j = 0; j < W; j++) begin : g_mask
    assign din_m[8*j +: 8] = data_in[8*j +: 8] & {8{keep_in[j]}};
  end

  always_comb begin
    case (state)
      FIRST:   ready_in = hdr_free && pay_free && !rst;
      STREAM:  ready_in = pay_free && !rst;
      default: ready_in = 1'b0;
    endcase
  end

  assign acc = valid_in && ready_in;

  always_comb begin
    k      = keep_popcount(MAX_BYTES'(keep_in));
    n      = (byte_extract_cnt == '0) ? W_B : CNT_W'(byte_extract_cnt);
    tot    = res_cnt + k;
    sh_hdr = {W_B - n, 3'b000};
    sh_pay = {n, 3'b000};
    sh_res = {W_B - res_cnt, 3'b000};
    // Residue sits MSB-aligned; the new beat is appended right behind its R bytes.
    wide   = {res, {DATA_WD{1'b0}}} | ({{DATA_WD{1'b0}}, din_m} << sh_res);

    state_nx   = state;
    res_nx     = res;
    res_cnt_nx = res_cnt;
    hdr_load   = 1'b0;
    hdr_d      = '0;
    hdr_k      = '0;
    pay_load   = 1'b0;
    pay_d      = '0;
    pay_k      = '0;
    pay_l      = 1'b0;

    case (state)
      FIRST: if (acc) begin
        hdr_load = 1'b1;
        hdr_d    = din_m >> sh_hdr;
        hdr_k    = W'(keep_from_cnt((k < n) ? k : n, W_B, 1'b0));
        if (last_in) begin
          res_nx     = '0;
          res_cnt_nx = '0;
          if (k > n) begin
            pay_load = 1'b1;
            pay_d    = din_m << sh_pay;
            pay_k    = W'(keep_from_cnt(k - n, W_B, 1'b1));
            pay_l    = 1'b1;
          end
        end else begin
          res_nx     = din_m << sh_pay;
          res_cnt_nx = W_B - n;
          state_nx   = STREAM;
        end
      end
      STREAM: if (acc) begin
        pay_load = 1'b1;
        pay_d    = wide[2*DATA_WD-1 -: DATA_WD];
        if (!last_in) begin
          pay_k  = '1;
          res_nx = wide[DATA_WD-1:0];
        end else if (tot <= W_B) begin
          pay_k      = W'(keep_from_cnt(tot, W_B, 1'b1));
          pay_l      = 1'b1;
          res_nx     = '0;
          res_cnt_nx = '0;
          state_nx   = FIRST;
        end else begin
          pay_k      = '1;
          res_nx     = wide[DATA_WD-1:0];
          res_cnt_nx = tot - W_B;
          state_nx   = FLUSH;
        end
      end
      FLUSH: if (pay_free) begin
        pay_load   = 1'b1;
        pay_d      = res;
        pay_k      = W'(keep_from_cnt(res_cnt, W_B, 1'b1));
        pay_l      = 1'b1;
        res_nx     = '0;
        res_cnt_nx = '0;
        state_nx   = FIRST;
      end
      default: state_nx = FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FIRST;
      res     <= '0;
      res_cnt <= '0;
    end else begin
      state   <= state_nx;
      res     <= res_nx;
      res_cnt <= res_cnt_nx;
    end
  end

  axis_reg_slice #(.PW(DATA_WD + W)) u_hdr (
    .clk   (clk),
    .rst   (rst),
    .load  (hdr_load),
    .d     ({hdr_d, hdr_k}),
    .free  (hdr_free),
    .valid (valid_header),
    .q     ({data_header, keep_header}),
    .ready (ready_header)
  );

  axis_reg_slice #(.PW(DATA_WD + W + 1)) u_pay (
    .clk   (clk),
    .rst   (rst),
    .load  (pay_load),
    .d     ({pay_d, pay_k, pay_l}),
    .free  (pay_free),
    .valid (valid_out),
    .q     ({data_out, keep_out, last_out}),
    .ready (ready_out)
  );
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Scoreboard bench: stimulus pushes expected header/payload beats, negedge monitors pop and compare.
module tb_axi_stream_extract_header;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic [1:0]  byte_extract_cnt = '0;
  logic        valid_header;
  logic [31:0] data_header;
  logic [3:0]  keep_header;
  logic        ready_header = 1'b1;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t hq[$];
  beat_t pq[$];
  beat_t he, pe;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_stream_extract_header dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .data_in          (data_in),
    .keep_in          (keep_in),
    .last_in          (last_in),
    .ready_in         (ready_in),
    .byte_extract_cnt (byte_extract_cnt),
    .valid_header     (valid_header),
    .data_header      (data_header),
    .keep_header      (keep_header),
    .ready_header     (ready_header),
    .valid_out        (valid_out),
    .data_out         (data_out),
    .keep_out         (keep_out),
    .last_out         (last_out),
    .ready_out        (ready_out)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask

  // Data bytes are compared only under the expected keep.
  task automatic cmp(input string nm, input beat_t a, input beat_t x);
    logic [31:0] m;
    m = {{8{x.k[3]}}, {8{x.k[2]}}, {8{x.k[1]}}, {8{x.k[0]}}};
    n_vec++;
    if (a.k !== x.k || a.l !== x.l || (a.d & m) !== (x.d & m)) begin
      n_err++;
      $display("FAIL %s: got %h/%b/%b expected %h/%b/%b", nm, a.d, a.k, a.l, x.d, x.k, x.l);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_header && ready_header) begin
        if (hq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL hdr_unexpected: got %h/%b expected none", data_header, keep_header);
        end else begin
          he = hq.pop_front();
          cmp("hdr", {data_header, keep_header, 1'b0}, he);
        end
      end
      if (valid_out && ready_out) begin
        if (pq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pay_unexpected: got %h/%b/%b expected none", data_out, keep_out, last_out);
        end else begin
          pe = pq.pop_front();
          cmp("pay", {data_out, keep_out, last_out}, pe);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] c);
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l; byte_extract_cnt = c;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted, valid_in still high.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] c);
    int t;
    logic a;
    drive(d, k, l, c);
    t = 0; a = 1'b0;
    while (!a && t < 200) begin
      @(negedge clk); a = ready_in; t++;
      @(posedge clk); #1;
    end
    if (!a) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: got no ready_in expected acceptance of %h", d);
    end
  endtask

  task automatic idle(input int cyc);
    valid_in = 1'b0;
    repeat (cyc) begin @(posedge clk); #1; end
  endtask

  task automatic push_h(input logic [31:0] d, input logic [3:0] k);
    hq.push_back({d, k, 1'b0});
  endtask

  task automatic push_p(input logic [31:0] d, input logic [3:0] k, input logic l);
    pq.push_back({d, k, l});
  endtask

  task automatic pkt3(input logic [1:0] c);
    send(32'h01020304, 4'b1111, 1'b0, c);
    send(32'h05060708, 4'b1111, 1'b0, c);
    send(32'h090A0B0C, 4'b1100, 1'b1, c);
  endtask

  initial begin
    #12;
    chk("rst_ready_in", {31'b0, ready_in}, 32'd0);
    chk("rst_valids", {29'b0, valid_header, valid_out, last_out}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_data_header", data_header, 32'd0);
    chk("rst_keeps", {24'b0, keep_out, keep_header}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // N=3
    push_h(32'h00010203, 4'b0111);
    push_p(32'h04050607, 4'b1111, 1'b0);
    push_p(32'h08090A00, 4'b1110, 1'b1);
    pkt3(2'd3);
    idle(3);

    // N=1, ends through FLUSH
    push_h(32'h00000001, 4'b0001);
    push_p(32'h02030405, 4'b1111, 1'b0);
    push_p(32'h06070809, 4'b1111, 1'b0);
    push_p(32'h0A000000, 4'b1000, 1'b1);
    pkt3(2'd1);
    valid_in = 1'b0;
    @(negedge clk);
    chk("flush_ready_in", {31'b0, ready_in}, 32'd0);
    @(posedge clk); #1;
    idle(3);

    // cnt=0 means a full-beat header, payload passes straight through
    push_h(32'h01020304, 4'b1111);
    push_p(32'h05060708, 4'b1111, 1'b0);
    push_p(32'h090A0B0C, 4'b1100, 1'b1);
    pkt3(2'd0);
    idle(3);

    // Payload backpressure mid-packet, N=3
    push_h(32'h00010203, 4'b0111);
    push_p(32'h04050607, 4'b1111, 1'b0);
    push_p(32'h08090A00, 4'b1110, 1'b1);
    send(32'h01020304, 4'b1111, 1'b0, 2'd3);
    send(32'h05060708, 4'b1111, 1'b0, 2'd3);
    ready_out = 1'b0;
    drive(32'h090A0B0C, 4'b1100, 1'b1, 2'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready_in", {31'b0, ready_in}, 32'd0);
      chk("bp_data_hold", data_out, 32'h04050607);
      @(posedge clk); #1;
    end
    ready_out = 1'b1;
    send(32'h090A0B0C, 4'b1100, 1'b1, 2'd3);
    idle(3);

    // Single-beat packets with the header channel stalled in between
    ready_header = 1'b0;
    push_h(32'h00112233, 4'b0111);
    push_p(32'h44000000, 4'b1000, 1'b1);
    push_h(32'h00112233, 4'b0111);
    send(32'h11223344, 4'b1111, 1'b1, 2'd3);
    drive(32'h11223344, 4'b1110, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hdr_stall_ready_in", {31'b0, ready_in}, 32'd0);
      @(posedge clk); #1;
    end
    ready_header = 1'b1;
    send(32'h11223344, 4'b1110, 1'b1, 2'd3);
    idle(3);

    // Reset after the second beat of an N=1 packet
    push_h(32'h00000001, 4'b0001);
    send(32'h01020304, 4'b1111, 1'b0, 2'd1);
    send(32'h05060708, 4'b1111, 1'b0, 2'd1);
    valid_in = 1'b0;
    chk("pre_rst_valid_out", {31'b0, valid_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_valids", {30'b0, valid_header, valid_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_h(32'h000000A1, 4'b0001);
    push_p(32'hA2A3A400, 4'b1110, 1'b1);
    send(32'hA1A2A3A4, 4'b1111, 1'b1, 2'd1);
    idle(5);

    chk("hdr_queue_drained", hq.size(), 32'd0);
    chk("pay_queue_drained", pq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
